instr_decode_stage: RTL

- Registered, parametrised instruction-decode pipeline stage for the TinyChip core. Sits between fetch and register-file/ALU.
- Splits each instruction word into bit_type, opcode, reg_dest, reg_op, funct and alu_src fields.
- Adds a two-word extended-immediate mode: a prefix word is followed by an immediate word.
- Uses valid/ready handshakes on both sides, a flush input, and a retired-instruction counter.

---
 rtl/instr_decode_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage for the TinyChip core: splits a fetch word into fields,
// merges prefix+immediate pairs into one bundle, and counts retired bundles.
module instr_decode_stage #(
  parameter int INSTR_W = 9,
  parameter int OPCODE_W = 3,
  parameter int REG_W = 2,
  parameter logic [OPCODE_W-1:0] EXT_OPCODE = 3'b111,
  parameter int CNT_W = 16,
  localparam int FUNCT_W = INSTR_W - 1 - OPCODE_W - 2 * REG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               bit_type,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]   reg_dest,
  output logic [REG_W-1:0]   reg_op,
  output logic [FUNCT_W-1:0] funct,
  output logic               alu_src,
  output logic               has_imm,
  output logic [INSTR_W-1:0] imm,
  output logic [CNT_W-1:0]   decode_count
);

  // Field layout of one instruction word, MSB first; its width is exactly INSTR_W.
  typedef struct packed {
    logic                bit_type;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    reg_dest;
    logic [REG_W-1:0]    reg_op;
    logic [FUNCT_W-1:0]  funct;
  } fields_t;

  typedef enum logic {
    IDLE,
    WAIT_IMM
  } state_t;

  state_t              state;
  fields_t             word;
  fields_t             prefix_q;
  fields_t             out_q;
  logic                out_valid_q;
  logic                has_imm_q;
  logic [INSTR_W-1:0]  imm_q;
  logic [CNT_W-1:0]    count_q;

  logic accept;
  logic out_fire;
  logic is_prefix;

  assign word      = fields_t'(instr);
  assign is_prefix = word.bit_type && (word.opcode == EXT_OPCODE);

  // NOTE: in_ready is combinational so a stalled output drops ready in the same cycle
  // instead of one cycle late, which would otherwise overwrite a held bundle.
  assign in_ready = ~reset & ~flush & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
  // the later completing-word assignment to out_valid_q deliberately overrides the handshake clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prefix_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      has_imm_q   <= 1'b0;
      imm_q       <= '0;
      count_q     <= '0;
    end else if (flush) begin
      // Fields stay stale; only the valid flag and the pending prefix are discarded.
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (out_fire) begin
        count_q     <= count_q + CNT_W'(1);
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state)
          IDLE: begin
            if (is_prefix) begin
              prefix_q <= word;
              state    <= WAIT_IMM;
            end else begin
              out_q       <= word;
              has_imm_q   <= 1'b0;
              imm_q       <= '0;
              out_valid_q <= 1'b1;
            end
          end
          WAIT_IMM: begin
            // Second word is raw immediate data even if it looks like another prefix.
            out_q       <= prefix_q;
            has_imm_q   <= 1'b1;
            imm_q       <= instr;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign bit_type     = out_q.bit_type;
  assign opcode       = out_q.opcode;
  assign reg_dest     = out_q.reg_dest;
  assign reg_op       = out_q.reg_op;
  assign funct        = out_q.funct;
  assign alu_src      = out_q.bit_type;
  assign has_imm      = has_imm_q;
  assign imm          = imm_q;
  assign decode_count = count_q;

endmodule
